pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter stage that consumes the word-aligned branch offset produced by the upstream left-shift-by-2 stage and drives the fetch address. Holds the PC register, computes sequential, branch, jump and jump-register targets, and buffers one redirect that arrives during a fetch stall. Sits between the execute-stage branch decision logic and instruction memory.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no sequential advance.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  32  sign-extended immediate already shifted left by 2.
- instr_pc4  in  32  PC+4 of the branch/jump instruction.
- jump  in  1  J/JAL request.
- jump_index  in  26  jump instruction index field.
- jump_reg  in  1  JR/JALR request.
- jump_reg_addr  in  32  register-sourced target.
- pc  out  32  current fetch address (registered).
- pc_plus4  out  32  pc + 4, combinational.
- redirect  out  1  registered pulse: pc holds a non-sequential target this cycle (flush strobe).
- misaligned  out  1  registered pulse with redirect: JR target had nonzero bits [1:0].

## Operation

- Targets: branch = instr_pc4 + branch_offset (32-bit, modulo 2^32); jump = {instr_pc4[31:28], jump_index, 2'b00}; jump-register = {jump_reg_addr[31:2], 2'b00}.
- Request priority within one cycle: jump_reg > jump > branch_taken. One selected target per cycle.
- States: RUN, PENDING (one target buffered), and DELAY (only with macro).
- RUN, stall=0, no request: pc <= pc_plus4.
- RUN, stall=0, request: pc <= target, redirect=1 next cycle.
- RUN, stall=1, request: pc held, target (and misaligned flag) captured, -> PENDING.
- RUN, stall=1, no request: pc held.
- PENDING, stall=1: pc held; new requests ignored (oldest instruction wins).
- PENDING, stall=0: pc <= buffered target, redirect=1, -> RUN; any request in that cycle is ignored.
- redirect and misaligned are single-cycle pulses, never asserted while stall held pc without a load.
- rst overrides everything, from any state: pc=RESET_PC, state RUN, buffer cleared, redirect=0, misaligned=0.

## Timing

- Request sampled at edge N (stall=0): pc = target and redirect=1 during cycle N+1. Latency one cycle.
- Stall released at edge M while PENDING: pc = buffered target during cycle M+1.
- pc_plus4 follows pc combinationally, zero cycles; 0xFFFFFFFC wraps to 0x00000000.
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, redirect=0, misaligned=0.
- Inputs other than rst are don't-care while rst=1.

## Configuration

- BRANCH_DELAY_SLOT_EN defined: accepted redirect (from RUN or PENDING, stall=0) first advances pc <= pc_plus4 (delay slot fetch) and enters DELAY holding the target; next non-stalled edge loads target, redirect=1, -> RUN. Stall in DELAY holds pc and target; requests in DELAY ignored.
- Not defined: DELAY state absent; redirects take effect on the accepting edge as above.

## Test plan

- Reset: RESET_PC=0x0040_0000, rst high 2 cycles -> pc=0x0040_0000, redirect=0; release -> pc 0x0040_0004, 0x0040_0008 on successive edges.
- Branch: instr_pc4=0x0040_0010, branch_offset=0xFFFF_FFF0, branch_taken one cycle -> next pc=0x0040_0000, redirect=1 for exactly one cycle.
- Priority/misalign: jump_reg=1 with jump_reg_addr=0x0040_0203, jump=1, branch_taken=1 same cycle -> pc=0x0040_0200, redirect=1, misaligned=1.
- Stall buffering: stall=1, jump with instr_pc4=0x0040_0010, jump_index=0x010_0040 -> pc held 3 cycles, second branch during stall ignored; stall=0 -> pc=0x0040_0100, redirect=1.
- Wrap and reset mid-pending: pc=0xFFFF_FFFC sequential -> 0x0000_0000; capture a target under stall, assert rst -> pc=RESET_PC, buffered target never loaded after stall release.
- With BRANCH_DELAY_SLOT_EN: branch at pc=0x0040_0008 to 0x0040_0100 -> pc 0x0040_000C, then 0x0040_0100 with redirect=1.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register with branch/jump/JR targeting and one-deep redirect buffer under stall.
// Optional BRANCH_DELAY_SLOT_EN: accepted redirects fetch the delay slot before loading the target.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] instr_pc4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        misaligned
);
  localparam logic [1:0] RUN = 2'd0, PENDING = 2'd1;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic [1:0] DELAY = 2'd2;
`endif
  logic [1:0] state;
  logic [31:0] hold_target, target;
  logic hold_mis, req, req_mis;
  always_comb begin
    req = jump_reg | jump | branch_taken;
    target = jump_reg ? {jump_reg_addr[31:2], 2'b00}
           : jump ? {instr_pc4[31:28], jump_index, 2'b00}
           : instr_pc4 + branch_offset;
    req_mis = jump_reg & (|jump_reg_addr[1:0]);
    pc_plus4 = pc + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= RUN;
      hold_target <= '0;
      hold_mis <= 1'b0;
      redirect <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      redirect <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        RUN:
          if (!stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
            pc <= pc_plus4;
            if (req) begin
              hold_target <= target;
              hold_mis <= req_mis;
              state <= DELAY;
            end
`else
            pc <= req ? target : pc_plus4;
            redirect <= req;
            misaligned <= req & req_mis;
`endif
          end else if (req) begin
            hold_target <= target;
            hold_mis <= req_mis;
            state <= PENDING;
          end
        PENDING:
          if (!stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
            pc <= pc_plus4;
            state <= DELAY;
`else
            pc <= hold_target;
            redirect <= 1'b1;
            misaligned <= hold_mis;
            state <= RUN;
`endif
          end
`ifdef BRANCH_DELAY_SLOT_EN
        DELAY:
          if (!stall) begin
            pc <= hold_target;
            redirect <= 1'b1;
            misaligned <= hold_mis;
            state <= RUN;
          end
`endif
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed test-plan steps plus randomized traffic against a queue-based reference model.
module tb_pc_next_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jump_reg = 1'b0;
  logic [31:0] branch_offset = '0, instr_pc4 = '0, jump_reg_addr = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] pc, pc_plus4;
  logic redirect, misaligned;
  int errors = 0, checks = 0;
  typedef struct { logic [31:0] t; logic m; } redir_t;
  redir_t pend_q[$], dly_q[$];
  logic [31:0] m_pc;
  logic m_red, m_mis;

  pc_next_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .instr_pc4(instr_pc4), .jump(jump),
    .jump_index(jump_index), .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
    .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the next fetch address should be given the architectural rules.
  task automatic model_edge();
    redir_t r;
    logic any;
    any = jump_reg | jump | branch_taken;
    r.m = jump_reg && (jump_reg_addr % 4 != 0);
    if (jump_reg) r.t = jump_reg_addr - (jump_reg_addr % 4);
    else if (jump) r.t = {instr_pc4[31:28], 28'h0} + {4'h0, jump_index, 2'b00};
    else r.t = instr_pc4 + branch_offset;
    m_red = 1'b0;
    m_mis = 1'b0;
    if (rst) begin
      m_pc = RST_PC;
      pend_q.delete();
      dly_q.delete();
    end else if (dly_q.size() > 0) begin
      if (!stall) begin
        m_pc = dly_q[0].t; m_red = 1'b1; m_mis = dly_q[0].m; dly_q.delete();
      end
    end else if (pend_q.size() > 0) begin
      if (!stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
        m_pc = m_pc + 4; dly_q.push_back(pend_q[0]);
`else
        m_pc = pend_q[0].t; m_red = 1'b1; m_mis = pend_q[0].m;
`endif
        pend_q.delete();
      end
    end else if (!stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
      m_pc = m_pc + 4;
      if (any) dly_q.push_back(r);
`else
      if (any) begin m_pc = r.t; m_red = 1'b1; m_mis = r.m; end
      else m_pc = m_pc + 4;
`endif
    end else if (any) pend_q.push_back(r);
  endtask

  task automatic cyc(input logic r, input logic s, input logic bt, input logic [31:0] off,
                     input logic [31:0] ip4, input logic j, input logic [25:0] ji,
                     input logic jr, input logic [31:0] jra);
    @(negedge clk);
    rst = r; stall = s; branch_taken = bt; branch_offset = off; instr_pc4 = ip4;
    jump = j; jump_index = ji; jump_reg = jr; jump_reg_addr = jra;
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("redirect", {31'b0, redirect}, {31'b0, m_red});
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
  endtask

  task automatic idle(input logic s);
    cyc(1'b0, s, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_pc = RST_PC;
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("reset_pc", pc, 32'h0040_0000);
    chk("reset_redirect", {31'b0, redirect}, 32'h0);
    idle(1'b0);
    chk("seq1", pc, 32'h0040_0004);
    idle(1'b0);
    chk("seq2", pc, 32'h0040_0008);
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0040_0010, 1'b0, 0, 1'b0, 0);
`ifndef BRANCH_DELAY_SLOT_EN
    chk("branch_pc", pc, 32'h0040_0000);
    chk("branch_redirect", {31'b0, redirect}, 32'h1);
`else
    chk("delay_slot_pc", pc, 32'h0040_000C);
    idle(1'b0);
    chk("delay_target_pc", pc, 32'h0040_0000);
    chk("delay_redirect", {31'b0, redirect}, 32'h1);
`endif
    idle(1'b0);
    chk("redirect_one_cycle", {31'b0, redirect}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 32'h0040_0010, 1'b1, 26'h123, 1'b1, 32'h0040_0203);
`ifndef BRANCH_DELAY_SLOT_EN
    chk("prio_pc", pc, 32'h0040_0200);
    chk("prio_mis", {31'b0, misaligned}, 32'h1);
`else
    idle(1'b0);
    chk("prio_pc", pc, 32'h0040_0200);
`endif
    cyc(1'b0, 1'b1, 1'b0, 0, 32'h0040_0010, 1'b1, 26'h010_0040, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 32'h80, 32'h0040_0010, 1'b0, 0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 32'h80, 32'h0040_0010, 1'b0, 0, 1'b0, 0);
    idle(1'b0);
`ifndef BRANCH_DELAY_SLOT_EN
    chk("stall_release_pc", pc, 32'h0040_0100);
`else
    idle(1'b0);
    chk("stall_release_pc", pc, 32'h0040_0100);
`endif
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1, 32'hFFFF_FFFC);
`ifdef BRANCH_DELAY_SLOT_EN
    idle(1'b0);
`endif
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0000_0000);
    idle(1'b0);
    chk("wrap_pc", pc, 32'h0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 32'h0000_8000);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("rst_pending_pc", pc, RST_PC);
    idle(1'b0);
    chk("pending_dropped", pc, 32'h0040_0004);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 40) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0, $urandom << 2,
          $urandom, ($urandom % 5) == 0, 26'($urandom), ($urandom % 6) == 0, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
